// File: rtl/pipemem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipemem_ctrl
//  Purpose  : MEM-stage controller. Issues word accesses to a variable-latency
//             data memory over a req/ack handshake, stalls the pipeline until
//             each access completes, and flags misaligned or timed-out accesses.
//  Revision : 1.0  initial release
// ============================================================================
module pipemem_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] mmo,
    output logic        stall,
    output logic        align_err,
    output logic        tmo_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_count;
    logic           r_load;
    logic           w_access;
    logic           w_aligned;
    logic           w_issue;
    logic           w_tmo_hit;
    logic           w_unused;

    // mwreg and mrn only travel alongside this stage to the MEM/WB register
    assign w_unused  = &{1'b0, mwreg, mrn};

    assign w_access  = mm2reg | mwmem;
    assign w_aligned = (malu[1:0] == 2'b00);
    assign w_issue   = (r_state == S_IDLE) && w_access && w_aligned;
    assign w_tmo_hit = (r_count == C_TMO_LAST);

    // stall covers the issuing IDLE cycle and every BUSY cycle; DONE releases
    assign stall     = w_issue || (r_state == S_BUSY);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; DONE always returns to IDLE so an access is never reissued
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_issue) w_next = S_BUSY;
            S_BUSY:  if (mem_ack || w_tmo_hit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus outputs, timeout counter, load data and one-cycle error pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_wdata <= 32'd0;
            mmo       <= 32'd0;
            align_err <= 1'b0;
            tmo_err   <= 1'b0;
            r_count   <= '0;
            r_load    <= 1'b0;
        end else begin
            align_err <= 1'b0;
            tmo_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_access && !w_aligned) begin
                        align_err <= 1'b1;
                        mmo       <= 32'd0;
                    end else if (w_access) begin
                        mem_req   <= 1'b1;
                        mem_we    <= mwmem;
                        mem_addr  <= malu[31:2];
                        mem_wdata <= mb;
                        r_load    <= mm2reg;
                        r_count   <= '0;
                    end
                end
                S_BUSY: begin
                    r_count <= r_count + CW'(1);
                    if (mem_ack) begin
                        // an ack on the last allowed cycle still completes normally
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            mmo <= mem_rdata;
                        end else if (r_load) begin
                            mmo <= 32'd0;
                        end
                    end else if (w_tmo_hit) begin
                        mem_req <= 1'b0;
                        tmo_err <= 1'b1;
                        mmo     <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipemem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipemem_ctrl
//  Purpose  : Self-checking bench for pipemem_ctrl with an expected-mmo queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipemem_ctrl;

    localparam int TIMEOUT = 64;
    localparam int CW      = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mwreg = 1'b0;
    logic        mm2reg = 1'b0;
    logic        mwmem = 1'b0;
    logic [31:0] malu = 32'd0;
    logic [31:0] mb = 32'd0;
    logic [4:0]  mrn = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] mmo;
    logic        stall;
    logic        align_err;
    logic        tmo_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_mmo;

    // results of the most recent run_access
    int          n_stall, n_req, n_idle, n_align, n_tmo;
    logic        done_ok, req_in_done, bus_moved, seen_we;
    logic [31:0] done_mmo, seen_wdata;
    logic [29:0] seen_addr;

    pipemem_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .mrn       (mrn),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mmo       (mmo),
        .stall     (stall),
        .align_err (align_err),
        .tmo_err   (tmo_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one instruction and acts as the memory: acks ack_dly cycles
    // after mem_req rises (ack_dly<0: never). Returns after the retiring edge.
    task automatic run_access(input logic ld, input logic st, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int ack_dly);
        int  age;
        bit  first;
        age = 0; first = 1'b1;
        n_stall = 0; n_req = 0; n_idle = 0; n_align = 0; n_tmo = 0;
        done_ok = 1'b0; req_in_done = 1'b0; bus_moved = 1'b0; done_mmo = 32'd0;
        seen_addr = 30'd0; seen_we = 1'b0; seen_wdata = 32'd0;
        mm2reg = ld; mwmem = st; malu = addr; mb = wd; mwreg = ld; mrn = 5'($urandom);
        for (int cyc = 0; cyc < TIMEOUT + 20; cyc++) begin
            #1;
            if (stall) begin
                n_stall++;
                if (!mem_req) n_idle++;
            end
            if (mem_req) begin
                n_req++;
                if (first) begin
                    seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata; first = 1'b0;
                end else if (mem_addr !== seen_addr || mem_we !== seen_we || mem_wdata !== seen_wdata) begin
                    bus_moved = 1'b1;
                end
                if (age == ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = rd;
                end
                age++;
            end
            if (!stall) begin
                done_ok = 1'b1; done_mmo = mmo; req_in_done = mem_req;
            end
            @(posedge clock);
            #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (align_err) n_align++;
            if (tmo_err) n_tmo++;
            if (done_ok) break;
        end
    endtask

    task automatic drop_inputs();
        mm2reg = 1'b0; mwmem = 1'b0; mwreg = 1'b0; malu = 32'd0; mb = 32'd0;
    endtask

    task automatic test_reset();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
        total++; if ({mem_we, mem_addr, mem_wdata} !== 63'd0) begin bad++; $display("FAIL rst_bus: got %h want 0", {mem_we, mem_addr, mem_wdata}); end
        total++; if (mmo !== 32'd0) begin bad++; $display("FAIL rst_mmo: got %h want 0", mmo); end
        total++; if ({stall, align_err, tmo_err} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {stall, align_err, tmo_err}); end
    endtask

    task automatic test_load();
        exp_q.push_back(32'hCAFEF00D);
        run_access(1'b1, 1'b0, 32'h0000_0104, 32'h5555_AAAA, 32'hCAFEF00D, 3);
        exp_mmo = exp_q.pop_front();
        total++; if (done_ok !== 1'b1) begin bad++; $display("FAIL load_done: got %b want 1", done_ok); end
        total++; if (seen_addr !== 30'h41) begin bad++; $display("FAIL load_addr: got %h want 41", seen_addr); end
        total++; if (seen_we !== 1'b0) begin bad++; $display("FAIL load_we: got %b want 0", seen_we); end
        total++; if (n_stall !== 5) begin bad++; $display("FAIL load_stall: got %0d want 5", n_stall); end
        total++; if (done_mmo !== exp_mmo) begin bad++; $display("FAIL load_mmo: got %h want %h", done_mmo, exp_mmo); end
        total++; if (bus_moved !== 1'b0) begin bad++; $display("FAIL load_bus_stable: got %b want 0", bus_moved); end
        drop_inputs();
    endtask

    task automatic test_store();
        exp_q.push_back(32'hCAFEF00D);  // a store leaves mmo untouched
        run_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_0001, 0);
        exp_mmo = exp_q.pop_front();
        total++; if (seen_we !== 1'b1) begin bad++; $display("FAIL store_we: got %b want 1", seen_we); end
        total++; if (seen_addr !== 30'h8) begin bad++; $display("FAIL store_addr: got %h want 8", seen_addr); end
        total++; if (seen_wdata !== 32'h1234_5678) begin bad++; $display("FAIL store_wdata: got %h want 12345678", seen_wdata); end
        total++; if (n_stall !== 2) begin bad++; $display("FAIL store_stall: got %0d want 2", n_stall); end
        total++; if (done_mmo !== exp_mmo) begin bad++; $display("FAIL store_mmo: got %h want %h", done_mmo, exp_mmo); end
        drop_inputs();
    endtask

    task automatic test_timeout();
        exp_q.push_back(32'd0);
        run_access(1'b1, 1'b0, 32'h0000_0300, 32'd0, 32'h7777_7777, -1);
        exp_mmo = exp_q.pop_front();
        drop_inputs();
        total++; if (done_ok !== 1'b1) begin bad++; $display("FAIL tmo_done: got %b want 1", done_ok); end
        total++; if (n_req !== TIMEOUT) begin bad++; $display("FAIL tmo_req_cycles: got %0d want %0d", n_req, TIMEOUT); end
        total++; if (n_tmo !== 1) begin bad++; $display("FAIL tmo_pulse: got %0d want 1", n_tmo); end
        total++; if (n_stall !== TIMEOUT + 1) begin bad++; $display("FAIL tmo_stall: got %0d want %0d", n_stall, TIMEOUT + 1); end
        total++; if (done_mmo !== exp_mmo) begin bad++; $display("FAIL tmo_mmo: got %h want %h", done_mmo, exp_mmo); end
        step();
        total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_single: got %b want 0", tmo_err); end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(32'h1111_2222);
        run_access(1'b1, 1'b0, 32'h0000_0400, 32'd0, 32'h1111_2222, 1);
        exp_mmo = exp_q.pop_front();
        total++; if (done_mmo !== exp_mmo) begin bad++; $display("FAIL b2b_mmo0: got %h want %h", done_mmo, exp_mmo); end
        total++; if (n_stall !== 3) begin bad++; $display("FAIL b2b_stall0: got %0d want 3", n_stall); end
        total++; if (req_in_done !== 1'b0) begin bad++; $display("FAIL b2b_req_done: got %b want 0", req_in_done); end
        exp_q.push_back(32'h3333_4444);
        run_access(1'b1, 1'b0, 32'h0000_0408, 32'd0, 32'h3333_4444, 1);
        exp_mmo = exp_q.pop_front();
        drop_inputs();
        total++; if (n_idle !== 1) begin bad++; $display("FAIL b2b_bubble: got %0d want 1", n_idle); end
        total++; if (seen_addr !== 30'h102) begin bad++; $display("FAIL b2b_addr1: got %h want 102", seen_addr); end
        total++; if (done_mmo !== exp_mmo) begin bad++; $display("FAIL b2b_mmo1: got %h want %h", done_mmo, exp_mmo); end
    endtask

    task automatic test_misaligned();
        run_access(1'b1, 1'b0, 32'h0000_0106, 32'd0, 32'h9999_9999, 0);
        drop_inputs();
        total++; if (n_stall !== 0) begin bad++; $display("FAIL align_stall: got %0d want 0", n_stall); end
        total++; if (n_req !== 0) begin bad++; $display("FAIL align_req: got %0d want 0", n_req); end
        total++; if (n_align !== 1) begin bad++; $display("FAIL align_pulse: got %0d want 1", n_align); end
        total++; if (mmo !== 32'd0) begin bad++; $display("FAIL align_mmo: got %h want 0", mmo); end
        step();
        total++; if ({align_err, mem_req} !== 2'b00) begin bad++; $display("FAIL align_after: got %b want 00", {align_err, mem_req}); end
    endtask

    task automatic test_ack_at_timeout();
        exp_q.push_back(32'h0BAD_BEEF);
        run_access(1'b1, 1'b0, 32'h0000_0500, 32'd0, 32'h0BAD_BEEF, TIMEOUT - 1);
        exp_mmo = exp_q.pop_front();
        drop_inputs();
        total++; if (n_tmo !== 0) begin bad++; $display("FAIL coinc_tmo: got %0d want 0", n_tmo); end
        total++; if (n_req !== TIMEOUT) begin bad++; $display("FAIL coinc_req: got %0d want %0d", n_req, TIMEOUT); end
        total++; if (done_mmo !== exp_mmo) begin bad++; $display("FAIL coinc_mmo: got %h want %h", done_mmo, exp_mmo); end
    endtask

    task automatic test_load_and_store();
        exp_q.push_back(32'd0);
        run_access(1'b1, 1'b1, 32'h0000_0600, 32'hA5A5_5A5A, 32'hFFFF_0000, 2);
        exp_mmo = exp_q.pop_front();
        drop_inputs();
        total++; if (seen_we !== 1'b1) begin bad++; $display("FAIL both_we: got %b want 1", seen_we); end
        total++; if (seen_wdata !== 32'hA5A5_5A5A) begin bad++; $display("FAIL both_wdata: got %h want a5a55a5a", seen_wdata); end
        total++; if (done_mmo !== exp_mmo) begin bad++; $display("FAIL both_mmo: got %h want %h", done_mmo, exp_mmo); end
    endtask

    task automatic test_async_reset();
        mm2reg = 1'b1; malu = 32'h0000_0700;
        step();
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL areset_pre_req: got %b want 1", mem_req); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL areset_req: got %b want 0", mem_req); end
        drop_inputs();
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL areset_stall: got %b want 0", stall); end
        step();
        #2;
        reset = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
        step();
        mem_ack = 1'b0;
        step();
        total++; if (mmo !== 32'd0) begin bad++; $display("FAIL areset_late_ack_mmo: got %h want 0", mmo); end
        total++; if ({mem_req, stall, tmo_err} !== 3'b000) begin bad++; $display("FAIL areset_idle: got %b want 000", {mem_req, stall, tmo_err}); end
    endtask

    initial begin
        reset = 1'b1;
        step();
        step();
        #2;
        reset = 1'b0;
        step();
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_back_to_back();
        test_misaligned();
        test_ack_at_timeout();
        test_load_and_store();
        test_async_reset();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
